coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front-end for the vending-machine FSM that turns raw, bouncy per-denomination coin-slot sensor lines into the clean 2-bit coin code the FSM consumes. Each line is synchronized and debounced. Exactly one single-cycle code is emitted per inserted coin. Multi-coin jams are flagged, and accepted coins are counted. Sits directly upstream of the credit/drop FSM; its `coin` output drives that FSM's `coin` input on the same clock.

## Interface
- `DEBOUNCE`, 4: consecutive cycles a synchronized sensor vector must hold before it is accepted (≥1).
- `COUNT_W`, 8: width of the accepted-coin counter.

- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `sense`  in  3  raw asynchronous sensor lines: [0] circle, [1] triangle, [2] pentagon; 1 = coin present.
- `enable`  in  1  1 = accept coins; 0 = coins are debounced and tracked but not emitted or counted.
- `coin`  out  2  registered coin code: 00 none, 01 circle, 10 triangle, 11 pentagon.
- `jam`  out  1  1 while the slot is jammed (more than one sensor line stable-high).
- `coin_count`  out  COUNT_W  number of coins emitted since reset; saturating.

## Operation
- Synchronizer: two flops per `sense` bit, giving `s`.
- Debouncer: registers `cand` (3b), `cnt` ($clog2(DEBOUNCE)+1 b), `stab` (3b).
  - If `s != cand`: `cand<=s`, `cnt<=0`.
  - Else if `cnt == DEBOUNCE-1`: `stab<=cand`, and `cnt` holds.
  - Else: `cnt++`.
- FSM states: IDLE, WAIT_CLEAR, JAM.
  - IDLE, `stab==000`: stay.
  - IDLE, `stab` one-hot: go to WAIT_CLEAR. If `enable=1`, also `coin<=` the code for that bit and `coin_count` increments.
  - IDLE, `stab` has ≥2 bits set: go to JAM. No coin is emitted.
  - WAIT_CLEAR, `stab==000`: go to IDLE.
  - WAIT_CLEAR, `stab` has ≥2 bits set: go to JAM.
  - WAIT_CLEAR, `stab` is a different one-hot value: stay, and emit nothing.
  - JAM, `stab==000`: go to IDLE. Otherwise stay.
- `coin` is 00 in every cycle except the single cycle after an IDLE→WAIT_CLEAR transition with `enable=1`.
- `jam` = (state == JAM), registered Moore output.
- `coin_count` saturates at 2^COUNT_W−1 and never wraps.
- `enable` is sampled only on the IDLE→WAIT_CLEAR transition. A coin rejected while `enable=0` is never emitted later, even if `enable` rises while the coin is still held.
- Reset clears the synchronizers, `cand`, `cnt`, `stab`, `coin`, `jam` and `coin_count`, and puts the state in IDLE.
  - A reset mid-debounce or mid-WAIT_CLEAR discards the coin in progress.
  - A line still held after reset is released is debounced from scratch and emitted once.

## Timing
- Reset: one edge with `reset=0` puts every output at 0 (`coin=00`, `jam=0`, `coin_count=0`) from that edge on.
- Latency: `sense` set up before edge 0 and held steady gives:
  - `s` valid after edge 1,
  - `cand` loaded at edge 2,
  - `stab` updated at edge DEBOUNCE+2,
  - `coin` (or `jam`) asserted after edge DEBOUNCE+3.
  - With DEBOUNCE=4: `coin` is high between edges 7 and 8.
- Glitch rejection: a pulse on `s` shorter than DEBOUNCE+1 cycles, or any vector toggling faster than that, never reaches `stab`.
- Emission rate: at most one coin per insertion, and at least DEBOUNCE+1 cycles of `stab==000` lie between two emissions.
- The downstream FSM samples `coin` every cycle and needs no handshake. The 1-cycle pulse is the whole contract.
- Simultaneous rise of two lines is handled as JAM. `jam` rises on the same edge `coin` would have, and `coin` stays 00.

## Test plan
- Clean circle (DEBOUNCE=4): `sense=001` held for 12 cycles, then 000 → `coin=01` only between edges 7–8, `coin_count=1`, `jam=0` throughout.
- Bouncy triangle: `sense[1]` toggles every 2 cycles for 10 cycles, then holds 1 → exactly one `coin=10` pulse, DEBOUNCE+3 edges after the last toggle; `coin_count=1`.
- Glitch: `sense=100` for 3 cycles, then 000 → `coin` stays 00 and `coin_count` stays 0.
- Jam: `sense=011` held → `jam=1` from edge 7 until DEBOUNCE+3 edges after release to 000; no coin is emitted. A following clean pentagon gives `coin=11`.
- Enable gating: `enable=0`, circle inserted, `enable` raised to 1 while the circle is still held, then released → no pulse, count unchanged. The next circle with `enable=1` is emitted.
- Saturation and reset (COUNT_W=2): five clean coins → `coin_count` reads 1,2,3,3,3. Then `reset=0` applied at edge 5 of a sixth insertion → all outputs 0 and no pulse. Holding `sense` after reset release → one pulse and `coin_count=1`.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronizes and debounces the three denomination sensors,
// emits one registered coin code per insertion, flags multi-coin jams, counts coins.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int COUNT_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         sense,
  input  logic               enable,
  output logic [1:0]         coin,
  output logic               jam,
  output logic [COUNT_W-1:0] coin_count
);

  localparam int CNT_W = $clog2(DEBOUNCE) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CLEAR = 2'd1,
    JAM        = 2'd2
  } state_t;

  logic [2:0]       s_meta;
  logic [2:0]       s;
  logic [2:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       stab;

  state_t           state;
  state_t           next_state;
  logic             emit;
  logic [1:0]       emit_code;
  logic             one_hot;
  logic             multi;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s_meta <= 3'b000;
      s      <= 3'b000;
    end else begin
      s_meta <= sense;
      s      <= s_meta;
    end
  end

  // Any change on s restarts the count; stab follows only after DEBOUNCE+1 equal samples.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cand <= 3'b000;
      cnt  <= '0;
      stab <= 3'b000;
    end else if (s != cand) begin
      cand <= s;
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      stab <= cand;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign one_hot = (stab != 3'b000) && ((stab & (stab - 3'd1)) == 3'b000);
  assign multi   = (stab != 3'b000) && !one_hot;

  always_comb begin
    emit_code = 2'b00;
    case (stab)
      3'b001:  emit_code = 2'b01;
      3'b010:  emit_code = 2'b10;
      3'b100:  emit_code = 2'b11;
      default: emit_code = 2'b00;
    endcase
  end

  // enable matters only on the IDLE -> WAIT_CLEAR step; a coin seen while disabled is gone for good.
  always_comb begin
    next_state = state;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        if (multi) begin
          next_state = JAM;
        end else if (one_hot) begin
          next_state = WAIT_CLEAR;
          emit       = enable;
        end
      end
      WAIT_CLEAR: begin
        if (stab == 3'b000) begin
          next_state = IDLE;
        end else if (multi) begin
          next_state = JAM;
        end
      end
      JAM: begin
        if (stab == 3'b000) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // coin is a bare one-cycle pulse: the downstream FSM samples it every cycle, no ready/ack exists.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      coin       <= 2'b00;
      coin_count <= '0;
    end else begin
      state <= next_state;
      coin  <= emit ? emit_code : 2'b00;
      if (emit && (coin_count != {COUNT_W{1'b1}})) begin
        coin_count <= coin_count + COUNT_W'(1);
      end
    end
  end

  assign jam = (state == JAM);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: vector table, hand-written corner sequences and a random
// phase, all checked every cycle against a window-based reference model.
module tb_coin_acceptor;

  localparam int DEB = 4;
  localparam int M_IDLE = 0;
  localparam int M_HELD = 1;
  localparam int M_JAM  = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] sense;
  logic       enable;
  logic [1:0] coin;
  logic       jam;
  logic [7:0] coin_count;
  logic [1:0] coin_s;
  logic       jam_s;
  logic [1:0] coin_count_s;

  always #5 clock = ~clock;

  coin_acceptor #(.DEBOUNCE(DEB), .COUNT_W(8)) dut (
    .clock(clock), .reset(reset), .sense(sense), .enable(enable),
    .coin(coin), .jam(jam), .coin_count(coin_count)
  );

  coin_acceptor #(.DEBOUNCE(DEB), .COUNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .sense(sense), .enable(enable),
    .coin(coin_s), .jam(jam_s), .coin_count(coin_count_s)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [2:0] m_s1, m_s2, m_stab;
  logic [2:0] win[$];
  int         m_mode;
  logic [1:0] m_coin;
  int         m_n;

  // observation of the main DUT for the timing checks
  int         edge_no, pulses, last_pulse_edge, jam_first, jam_last;
  logic [1:0] last_code;

  typedef struct {
    logic [2:0] sense;
    logic       enable;
    logic [1:0] coin;
    logic       jam;
    logic [7:0] count;
  } vec_t;
  vec_t tbl[40];

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // stab takes value v once the last DEB+1 synchronized samples all equal v;
  // the slot logic reacts to the stable value seen before the edge.
  task automatic model_step(input logic [2:0] sv, input logic ev, input logic rv);
    logic [2:0] s_now;
    logic [2:0] old_stab;
    int         pc;
    bit         same;
    if (!rv) begin
      m_s1 = 3'b000; m_s2 = 3'b000; m_stab = 3'b000;
      win.delete();
      m_mode = M_IDLE; m_coin = 2'b00; m_n = 0;
    end else begin
      s_now    = m_s2;
      old_stab = m_stab;
      win.push_back(s_now);
      if (win.size() > DEB + 1) void'(win.pop_front());
      if (win.size() == DEB + 1) begin
        same = 1'b1;
        foreach (win[i]) if (win[i] != s_now) same = 1'b0;
        if (same) m_stab = s_now;
      end
      pc     = $countones(old_stab);
      m_coin = 2'b00;
      case (m_mode)
        M_IDLE: begin
          if (pc == 1) begin
            m_mode = M_HELD;
            if (ev) begin
              m_coin = old_stab[0] ? 2'd1 : (old_stab[1] ? 2'd2 : 2'd3);
              m_n++;
            end
          end else if (pc >= 2) begin
            m_mode = M_JAM;
          end
        end
        M_HELD: begin
          if (pc == 0) m_mode = M_IDLE;
          else if (pc >= 2) m_mode = M_JAM;
        end
        default: begin
          if (pc == 0) m_mode = M_IDLE;
        end
      endcase
      m_s2 = m_s1;
      m_s1 = sv;
    end
  endtask

  task automatic cycle(input logic [2:0] sv, input logic ev, input logic rv);
    sense = sv; enable = ev; reset = rv;
    @(posedge clock);
    model_step(sv, ev, rv);
    #1;
    chk("coin", coin, m_coin);
    chk("jam", jam, (m_mode == M_JAM));
    chk("count", coin_count, min_i(m_n, 255));
    chk("coin_sat", coin_s, m_coin);
    chk("jam_sat", jam_s, (m_mode == M_JAM));
    chk("count_sat", coin_count_s, min_i(m_n, 3));
    if (coin != 2'b00) begin
      pulses++;
      last_pulse_edge = edge_no;
      last_code = coin;
    end
    if (jam) begin
      if (jam_first < 0) jam_first = edge_no;
      jam_last = edge_no;
    end
    edge_no++;
  endtask

  task automatic hold(input logic [2:0] sv, input logic ev, input int n);
    for (int i = 0; i < n; i++) cycle(sv, ev, 1'b1);
  endtask

  task automatic clear_obs();
    edge_no = 0; pulses = 0; last_pulse_edge = -1;
    jam_first = -1; jam_last = -1; last_code = 2'b00;
  endtask

  task automatic begin_seq();
    cycle(3'b000, 1'b1, 1'b0);
    clear_obs();
  endtask

  initial begin
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};
    sense = 3'b000; enable = 1'b1; reset = 1'b0;
    clear_obs();

    // circle then triangle, edge numbers relative to the first row
    for (int i = 0; i < 40; i++) begin
      tbl[i].enable = 1'b1;
      tbl[i].jam    = 1'b0;
      if (i < 12)                 tbl[i].sense = 3'b001;
      else if (i >= 20 && i < 32) tbl[i].sense = 3'b010;
      else                        tbl[i].sense = 3'b000;
      tbl[i].coin  = (i == 7) ? 2'b01 : ((i == 27) ? 2'b10 : 2'b00);
      tbl[i].count = (i >= 27) ? 8'd2 : ((i >= 7) ? 8'd1 : 8'd0);
    end

    // reset state
    cycle(3'b000, 1'b1, 1'b0);
    chk("reset_coin", coin, 0);
    chk("reset_jam", jam, 0);
    chk("reset_count", coin_count, 0);
    cycle(3'b000, 1'b1, 1'b0);
    clear_obs();

    for (int i = 0; i < 40; i++) begin
      cycle(tbl[i].sense, tbl[i].enable, 1'b1);
      chk($sformatf("tbl%0d_coin", i), coin, tbl[i].coin);
      chk($sformatf("tbl%0d_jam", i), jam, tbl[i].jam);
      chk($sformatf("tbl%0d_count", i), coin_count, tbl[i].count);
    end

    // bouncy triangle: last toggle at edge 8, pulse DEB+3 edges later
    begin_seq();
    for (int i = 0; i < 10; i++) cycle({1'b0, ((i / 2) % 2 == 0), 1'b0}, 1'b1, 1'b1);
    hold(3'b010, 1'b1, 16);
    hold(3'b000, 1'b1, 10);
    chk("bounce_pulses", pulses, 1);
    chk("bounce_edge", last_pulse_edge, 8 + DEB + 3);
    chk("bounce_code", last_code, 2);
    chk("bounce_count", coin_count, 1);

    // glitch shorter than DEB+1 cycles
    begin_seq();
    hold(3'b100, 1'b1, 3);
    hold(3'b000, 1'b1, 10);
    chk("glitch_pulses", pulses, 0);
    chk("glitch_count", coin_count, 0);

    // jam held for 15 cycles, released before edge 15, then a pentagon
    begin_seq();
    hold(3'b011, 1'b1, 15);
    hold(3'b000, 1'b1, 12);
    chk("jam_first", jam_first, 7);
    chk("jam_last", jam_last, 15 + DEB + 2);
    chk("jam_pulses", pulses, 0);
    hold(3'b100, 1'b1, 12);
    hold(3'b000, 1'b1, 8);
    chk("jam_penta_pulses", pulses, 1);
    chk("jam_penta_code", last_code, 3);
    chk("jam_penta_count", coin_count, 1);

    // enable gating: raised only after the coin was already seen
    begin_seq();
    hold(3'b001, 1'b0, 10);
    hold(3'b001, 1'b1, 6);
    hold(3'b000, 1'b1, 10);
    chk("gate_pulses", pulses, 0);
    chk("gate_count", coin_count, 0);
    hold(3'b001, 1'b1, 12);
    hold(3'b000, 1'b1, 8);
    chk("gate_next_pulses", pulses, 1);
    chk("gate_next_code", last_code, 1);
    chk("gate_next_count", coin_count, 1);

    // saturation of the 2-bit counter, then reset in the middle of a coin
    begin_seq();
    for (int k = 0; k < 5; k++) begin
      hold(3'b001, 1'b1, 12);
      hold(3'b000, 1'b1, 8);
      chk($sformatf("sat%0d_count_sat", k), coin_count_s, sat_exp[k]);
      chk($sformatf("sat%0d_count", k), coin_count, k + 1);
    end
    clear_obs();
    hold(3'b001, 1'b1, 5);
    cycle(3'b001, 1'b1, 1'b0);
    chk("midreset_coin", coin, 0);
    chk("midreset_jam", jam, 0);
    chk("midreset_count", coin_count, 0);
    chk("midreset_count_sat", coin_count_s, 0);
    hold(3'b001, 1'b1, 12);
    hold(3'b000, 1'b1, 8);
    chk("after_reset_pulses", pulses, 1);
    chk("after_reset_edge", last_pulse_edge, 13);
    chk("after_reset_count", coin_count, 1);
    chk("after_reset_count_sat", coin_count_s, 1);

    // random segments against the model
    begin_seq();
    for (int seg = 0; seg < 300; seg++) begin
      int         len;
      logic [2:0] v;
      logic       e;
      len = $urandom_range(1, 12);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: v = 3'b000;
        4, 5, 6, 7: v = 3'b001 << $urandom_range(0, 2);
        default:    v = 3'($urandom_range(0, 7));
      endcase
      e = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 40) == 0) cycle(v, e, 1'b0);
      else hold(v, e, len);
    end
    hold(3'b000, 1'b1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
